// File: rtl/tx_intf_mq_pkg.sv
// rtl/tx_intf_mq_pkg.sv - shared FSM encodings, error bit indices and width helpers for the multi-queue TX ingress
package tx_intf_mq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam int ERR_DESC_OVF  = 0;
  localparam int ERR_BAD_QUEUE = 1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Index widths must never collapse to zero bits, even for a single entry.
  function automatic int clog2_min1(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/tx_intf_sync_fifo.sv
// rtl/tx_intf_sync_fifo.sv - single-clock FIFO with registered read data, flags and occupancy
module tx_intf_sync_fifo
  import tx_intf_mq_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2_min1(DEPTH),
  localparam int CW    = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CW-1:0]    count_next;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // A pop of an empty FIFO leaves rd_data untouched so the consumer sees a stable word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/tx_intf_s_axis_mq.sv
// rtl/tx_intf_s_axis_mq.sv - steers one DMA stream packet at a time into per-queue data FIFOs
// and commits a per-queue descriptor (cts/total plus TSF) when the packet completes.
module tx_intf_s_axis_mq
  import tx_intf_mq_pkg::*;
#(
  parameter  int C_S_AXIS_TDATA_WIDTH   = 64,
  parameter  int NUM_QUEUE              = 4,
  parameter  int DATA_FIFO_DEPTH        = 4096,
  parameter  int DESC_FIFO_DEPTH        = 64,
  parameter  int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter  int TSF_TIMER_WIDTH        = 64,
  localparam int QW                     = clog2_min1(NUM_QUEUE),
  localparam int DCW                    = clog2(DATA_FIFO_DEPTH) + 1,
  localparam int KCW                    = clog2(DESC_FIFO_DEPTH) + 1
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] S_AXIS_NUM_DMA_SYMBOL,
  input  logic [QW:0]                       s_axis_queue_sel,
  input  logic [31:0]                       cts_toself_config,
  input  logic [31:0]                       num_dma_symbol_total,
  input  logic [TSF_TIMER_WIDTH-1:0]        tsf_config,
  input  logic [QW-1:0]                     acc_queue_sel,
  input  logic                              ACC_ASK_DATA,
  input  logic                              ACC_ASK_DMG,
  input  logic                              ACC_ASK_TSF,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   DATA_TO_ACC,
  output logic [63:0]                       DMG_TO_ACC,
  output logic [TSF_TIMER_WIDTH-1:0]        TSF_TO_ACC,
  output logic [NUM_QUEUE-1:0]              EMPTYN_TO_ACC,
  output logic [NUM_QUEUE-1:0]              EMPTY_DMG_TO_ACC,
  output logic [NUM_QUEUE*DCW-1:0]          data_count,
  output logic [NUM_QUEUE*KCW-1:0]          desc_count,
  output logic [1:0]                        err_sticky,
  input  logic                              err_clear
);

  localparam int          SW     = MAX_BIT_NUM_DMA_SYMBOL;
  localparam logic [QW:0] NQ_LIM = (QW + 1)'(NUM_QUEUE);

  logic [1:0]    state;
  logic [QW:0]   q;
  logic [SW-1:0] n;
  logic [SW-1:0] wp;
  logic [QW-1:0] q_idx;
  logic          beat;
  logic          last_beat;
  logic [1:0]    err_set;
  logic          acc_ok;

  logic [NUM_QUEUE-1:0] data_full;
  logic [NUM_QUEUE-1:0] data_empty;
  logic [NUM_QUEUE-1:0] dmg_empty;
  logic [NUM_QUEUE-1:0] tsf_empty;
  logic [NUM_QUEUE-1:0] desc_full;

  logic [C_S_AXIS_TDATA_WIDTH-1:0] data_rd [NUM_QUEUE];
  logic [63:0]                     dmg_rd  [NUM_QUEUE];
  logic [TSF_TIMER_WIDTH-1:0]      tsf_rd  [NUM_QUEUE];

  logic [QW-1:0] data_sel;
  logic [QW-1:0] dmg_sel;
  logic [QW-1:0] tsf_sel;

  assign q_idx     = q[QW-1:0];
  assign beat      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_beat = beat && ((wp == n) || S_AXIS_TLAST);
  assign acc_ok    = ({1'b0, acc_queue_sel} < NQ_LIM);

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    case (state)
      ST_WRITE: S_AXIS_TREADY = (wp <= n) && !data_full[q_idx];
      ST_DRAIN: S_AXIS_TREADY = 1'b1;
      default:  S_AXIS_TREADY = 1'b0;
    endcase
  end

  // Packet length and queue are frozen at the first valid beat; IDLE never accepts data.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state <= ST_IDLE;
      q     <= '0;
      n     <= '0;
      wp    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (S_AXIS_TVALID) begin
            q     <= s_axis_queue_sel;
            n     <= S_AXIS_NUM_DMA_SYMBOL;
            wp    <= '0;
            state <= (s_axis_queue_sel >= NQ_LIM) ? ST_DRAIN : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (beat) wp <= wp + SW'(1);
          if (last_beat) state <= ST_COMMIT;
        end
        ST_DRAIN: begin
          if (beat) wp <= wp + SW'(1);
          if (last_beat) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign err_set[ERR_DESC_OVF]  = (state == ST_COMMIT) && desc_full[q_idx];
  assign err_set[ERR_BAD_QUEUE] = (state == ST_DRAIN);

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= (err_clear ? 2'b00 : err_sticky) | err_set;
    end
  end

  for (genvar i = 0; i < NUM_QUEUE; i++) begin : g_queue
    logic           data_wr;
    logic           data_pop;
    logic           desc_wr;
    logic           dmg_full;
    logic           tsf_full;
    logic [DCW-1:0] data_cnt;
    logic [KCW-1:0] dmg_cnt;
    logic [KCW-1:0] tsf_cnt;

    assign data_wr  = (state == ST_WRITE) && beat && (q_idx == QW'(i));
    assign data_pop = ACC_ASK_DATA && (acc_queue_sel == QW'(i));
    assign desc_wr  = (state == ST_COMMIT) && (q_idx == QW'(i)) && !desc_full[i];

    tx_intf_sync_fifo #(
      .WIDTH (C_S_AXIS_TDATA_WIDTH),
      .DEPTH (DATA_FIFO_DEPTH)
    ) u_data_fifo (
      .clk     (S_AXIS_ACLK),
      .rst_n   (S_AXIS_ARESETN),
      .wr_en   (data_wr),
      .wr_data (S_AXIS_TDATA),
      .rd_en   (data_pop),
      .rd_data (data_rd[i]),
      .full    (data_full[i]),
      .empty   (data_empty[i]),
      .count   (data_cnt)
    );

    tx_intf_sync_fifo #(
      .WIDTH (64),
      .DEPTH (DESC_FIFO_DEPTH)
    ) u_dmg_fifo (
      .clk     (S_AXIS_ACLK),
      .rst_n   (S_AXIS_ARESETN),
      .wr_en   (desc_wr),
      .wr_data ({cts_toself_config, num_dma_symbol_total}),
      .rd_en   (ACC_ASK_DMG && (acc_queue_sel == QW'(i))),
      .rd_data (dmg_rd[i]),
      .full    (dmg_full),
      .empty   (dmg_empty[i]),
      .count   (dmg_cnt)
    );

    tx_intf_sync_fifo #(
      .WIDTH (TSF_TIMER_WIDTH),
      .DEPTH (DESC_FIFO_DEPTH)
    ) u_tsf_fifo (
      .clk     (S_AXIS_ACLK),
      .rst_n   (S_AXIS_ARESETN),
      .wr_en   (desc_wr),
      .wr_data (tsf_config),
      .rd_en   (ACC_ASK_TSF && (acc_queue_sel == QW'(i))),
      .rd_data (tsf_rd[i]),
      .full    (tsf_full),
      .empty   (tsf_empty[i]),
      .count   (tsf_cnt)
    );

    // The two descriptor halves drain independently; report the side that still holds more.
    assign desc_full[i]                = dmg_full || tsf_full;
    assign desc_count[i*KCW +: KCW]    = (dmg_cnt > tsf_cnt) ? dmg_cnt : tsf_cnt;
    assign data_count[i*DCW +: DCW]    = data_cnt;
    assign EMPTYN_TO_ACC[i]            = !data_empty[i];
    assign EMPTY_DMG_TO_ACC[i]         = dmg_empty[i] && tsf_empty[i];
  end

  // Output selects only move on a successful pop, so an ignored pop keeps the outputs steady.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      data_sel <= '0;
      dmg_sel  <= '0;
      tsf_sel  <= '0;
    end else if (acc_ok) begin
      if (ACC_ASK_DATA && !data_empty[acc_queue_sel]) data_sel <= acc_queue_sel;
      if (ACC_ASK_DMG && !dmg_empty[acc_queue_sel])   dmg_sel  <= acc_queue_sel;
      if (ACC_ASK_TSF && !tsf_empty[acc_queue_sel])   tsf_sel  <= acc_queue_sel;
    end
  end

  assign DATA_TO_ACC = data_rd[data_sel];
  assign DMG_TO_ACC  = dmg_rd[dmg_sel];
  assign TSF_TO_ACC  = tsf_rd[tsf_sel];

endmodule

// File: tb/tb_tx_intf_s_axis_mq.sv
// tb/tb_tx_intf_s_axis_mq.sv - directed-vector bench for the multi-queue TX ingress
module tb_tx_intf_s_axis_mq;

  localparam int DCW = 5;
  localparam int KCW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [13:0] num_sym;
  logic [2:0]  qsel;
  logic [31:0] cts;
  logic [31:0] total;
  logic [63:0] tsf;
  logic [1:0]  acc_sel;
  logic        ask_data;
  logic        ask_dmg;
  logic        ask_tsf;
  logic [63:0] data_out;
  logic [63:0] dmg_out;
  logic [63:0] tsf_out;
  logic [3:0]  emptyn;
  logic [3:0]  empty_dmg;
  logic [19:0] data_count;
  logic [15:0] desc_count;
  logic [1:0]  err;
  logic        err_clear;

  int n_vec = 0;
  int n_bad = 0;
  int acc;
  int acc_sum;

  always #5 clk = ~clk;

  tx_intf_s_axis_mq #(
    .C_S_AXIS_TDATA_WIDTH   (64),
    .NUM_QUEUE              (4),
    .DATA_FIFO_DEPTH        (16),
    .DESC_FIFO_DEPTH        (8),
    .MAX_BIT_NUM_DMA_SYMBOL (14),
    .TSF_TIMER_WIDTH        (64)
  ) dut (
    .S_AXIS_ACLK           (clk),
    .S_AXIS_ARESETN        (rst_n),
    .S_AXIS_TDATA          (tdata),
    .S_AXIS_TVALID         (tvalid),
    .S_AXIS_TLAST          (tlast),
    .S_AXIS_TREADY         (tready),
    .S_AXIS_NUM_DMA_SYMBOL (num_sym),
    .s_axis_queue_sel      (qsel),
    .cts_toself_config     (cts),
    .num_dma_symbol_total  (total),
    .tsf_config            (tsf),
    .acc_queue_sel         (acc_sel),
    .ACC_ASK_DATA          (ask_data),
    .ACC_ASK_DMG           (ask_dmg),
    .ACC_ASK_TSF           (ask_tsf),
    .DATA_TO_ACC           (data_out),
    .DMG_TO_ACC            (dmg_out),
    .TSF_TO_ACC            (tsf_out),
    .EMPTYN_TO_ACC         (emptyn),
    .EMPTY_DMG_TO_ACC      (empty_dmg),
    .data_count            (data_count),
    .desc_count            (desc_count),
    .err_sticky            (err),
    .err_clear             (err_clear)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DCW-1:0] dcnt(input int q);
    return data_count[q*DCW +: DCW];
  endfunction

  function automatic logic [KCW-1:0] kcnt(input int q);
    return desc_count[q*KCW +: KCW];
  endfunction

  // Offers beats base+i; a beat counts when tready is high mid-cycle before the edge.
  task automatic send_pkt(input int q, input int n, input int nbeats, input int last_idx,
                          input logic [63:0] base, input int max_cycles, output int accepted);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    accepted = 0;
    qsel = 3'(q);
    num_sym = 14'(n);
    while (i < nbeats && cyc < max_cycles) begin
      tdata  = base + 64'(i);
      tlast  = (i == last_idx);
      tvalid = 1'b1;
      @(negedge clk);
      if (tready) begin
        i++;
        accepted++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pop(input int q, input bit d, input bit g, input bit t);
    acc_sel  = 2'(q);
    ask_data = d;
    ask_dmg  = g;
    ask_tsf  = t;
    @(posedge clk);
    #1;
    ask_data = 1'b0;
    ask_dmg  = 1'b0;
    ask_tsf  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tready"}, 64'(tready), 64'h0);
    check({tag, "_emptyn"}, 64'(emptyn), 64'h0);
    check({tag, "_empty_dmg"}, 64'(empty_dmg), 64'hF);
    check({tag, "_data_count"}, 64'(data_count), 64'h0);
    check({tag, "_desc_count"}, 64'(desc_count), 64'h0);
    check({tag, "_err"}, 64'(err), 64'h0);
    check({tag, "_data_out"}, data_out, 64'h0);
    check({tag, "_dmg_out"}, dmg_out, 64'h0);
    check({tag, "_tsf_out"}, tsf_out, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0; num_sym = '0; qsel = '0;
    cts = '0; total = '0; tsf = '0; acc_sel = '0;
    ask_data = 1'b0; ask_dmg = 1'b0; ask_tsf = 1'b0; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Queue 2, n=3, four beats with TLAST on the last.
    cts = 32'h1111_2222; total = 32'h0000_0004; tsf = 64'hDEAD_BEEF_0000_0001;
    send_pkt(2, 3, 4, 3, 64'hA0, 20, acc);
    check("q2_accepted", 64'(acc), 64'd4);
    check("q2_empty_dmg_in_commit", 64'(empty_dmg[2]), 64'h1);
    @(posedge clk);
    #1;
    check("q2_empty_dmg_after_commit", 64'(empty_dmg[2]), 64'h0);
    check("q2_data_count", 64'(dcnt(2)), 64'd4);
    check("q2_desc_count", 64'(kcnt(2)), 64'd1);
    check("q2_emptyn", 64'(emptyn), 64'b0100);
    for (int i = 0; i < 4; i++) begin
      acc_sel = 2'd2;
      ask_data = 1'b1;
      @(negedge clk);
      check("q2_data_before_edge", data_out, (i == 0) ? 64'h0 : 64'hA0 + 64'(i - 1));
      @(posedge clk);
      #1;
      ask_data = 1'b0;
      check("q2_data_read", data_out, 64'hA0 + 64'(i));
    end
    pop(2, 1'b0, 1'b1, 1'b1);
    check("q2_dmg", dmg_out, 64'h1111_2222_0000_0004);
    check("q2_tsf", tsf_out, 64'hDEAD_BEEF_0000_0001);
    check("q2_empty_dmg_drained", 64'(empty_dmg[2]), 64'h1);
    check("q2_emptyn_drained", 64'(emptyn[2]), 64'h0);
    pop(2, 1'b1, 1'b1, 1'b0);
    check("q2_empty_pop_data_holds", data_out, 64'hA3);
    check("q2_empty_pop_dmg_holds", dmg_out, 64'h1111_2222_0000_0004);

    // Queue 0, n=7, TLAST on beat 3 ends the packet early.
    cts = 32'h3333_4444; total = 32'd8; tsf = 64'h10;
    send_pkt(0, 7, 4, 3, 64'hB0, 20, acc);
    check("q0_accepted", 64'(acc), 64'd4);
    check("q0_tready_commit", 64'(tready), 64'h0);
    @(posedge clk);
    #1;
    check("q0_tready_idle", 64'(tready), 64'h0);
    check("q0_data_count", 64'(dcnt(0)), 64'd4);
    check("q0_desc_count", 64'(kcnt(0)), 64'd1);

    // Nine one-beat packets into queue 1 overflow its 8-entry descriptor store.
    acc_sum = 0;
    for (int k = 0; k < 9; k++) begin
      send_pkt(1, 0, 1, 0, 64'hC0 + 64'(k), 20, acc);
      acc_sum += acc;
    end
    check("q1_accepted", 64'(acc_sum), 64'd9);
    @(posedge clk);
    #1;
    check("q1_desc_count", 64'(kcnt(1)), 64'd8);
    check("q1_data_count", 64'(dcnt(1)), 64'd9);
    check("q1_err_ovf", 64'(err), 64'b01);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    check("err_cleared", 64'(err), 64'b00);

    // Invalid queue: beats drained, nothing stored.
    send_pkt(4, 4, 5, 4, 64'hD0, 20, acc);
    check("bad_q_accepted", 64'(acc), 64'd5);
    @(posedge clk);
    #1;
    check("bad_q_err", 64'(err), 64'b10);
    check("bad_q_data_count", 64'(data_count), {5'd0, 5'd0, 5'd0, 5'd9, 5'd4});
    check("bad_q_desc_count", 64'(desc_count), {4'd0, 4'd0, 4'd8, 4'd1});

    // Queue 3: 20-beat packet into a 16-word FIFO stalls until reads free space.
    send_pkt(3, 19, 20, 19, 64'h100, 30, acc);
    check("q3_accepted_until_full", 64'(acc), 64'd16);
    check("q3_tready_full", 64'(tready), 64'h0);
    check("q3_data_count_full", 64'(dcnt(3)), 64'd16);
    for (int i = 0; i < 4; i++) begin
      pop(3, 1'b1, 1'b0, 1'b0);
      check("q3_read", data_out, 64'h100 + 64'(i));
    end
    check("q3_data_count_after_reads", 64'(dcnt(3)), 64'd12);
    send_pkt(3, 19, 4, 3, 64'h110, 20, acc);
    check("q3_accepted_rest", 64'(acc), 64'd4);
    check("q3_data_count_refull", 64'(dcnt(3)), 64'd16);
    @(posedge clk);
    #1;
    check("q3_desc_count", 64'(kcnt(3)), 64'd1);

    // Asynchronous reset in the middle of a 6-beat packet.
    send_pkt(2, 5, 2, 5, 64'hE0, 20, acc);
    check("rst_pkt_accepted", 64'(acc), 64'd2);
    tdata = 64'hE2;
    tvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cts = 32'h5555_6666; total = 32'd2; tsf = 64'h77;
    send_pkt(0, 1, 2, 1, 64'hF0, 20, acc);
    check("post_rst_accepted", 64'(acc), 64'd2);
    @(posedge clk);
    #1;
    check("post_rst_data_count", 64'(dcnt(0)), 64'd2);
    check("post_rst_desc_count", 64'(kcnt(0)), 64'd1);
    pop(0, 1'b1, 1'b1, 1'b1);
    check("post_rst_data", data_out, 64'hF0);
    check("post_rst_dmg", dmg_out, 64'h5555_6666_0000_0002);
    check("post_rst_tsf", tsf_out, 64'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
